// File: rtl/i2s_ctrl_pkg.sv
// Shared types and constants for the I2S capture controller: FSM encoding,
// default widths and the RUN-state watchdog limit.
package i2s_ctrl_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int CW_DEFAULT = 16;

  localparam int                WDOG_W     = 16;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/i2s_capture_ctrl.sv
// I2S capture session controller: flushes stale FIFO words, streams N (or unlimited) samples,
// drains the output register; optional RUN watchdog under I2S_CAPTURE_CTRL_TIMEOUT_EN.
module i2s_capture_ctrl
  import i2s_ctrl_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] sample_count,
  input  logic          clear_overrun,
  output logic          i2s_en,
  output logic          fifo_rd,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic [DW-1:0] fifo_rdata,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          overrun,
`ifdef I2S_CAPTURE_CTRL_TIMEOUT_EN
  output logic          timeout,
`endif
  output logic [CW-1:0] remaining
);

  state_t        state_q;
  logic          m_valid_q, m_last_q, done_q, aborted_q, overrun_q, cont_q;
  logic [DW-1:0] m_data_q;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          in_run, take, pop, last_pop, stop_run, wdog_expired;

`ifdef I2S_CAPTURE_CTRL_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              timeout_q;

  assign wdog_expired = in_run && (wdog_q == WDOG_LIMIT);
  assign timeout      = timeout_q;

  // Counts idle RUN cycles; any pop or leaving RUN restarts the count.
  always_ff @(posedge clk) begin
    if (rst || !in_run || pop) begin
      wdog_q <= '0;
    end else if (!wdog_expired) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    in_run      = (state_q == RUN);
    take        = m_valid_q & m_ready;
    stop_run    = in_run & (stop | wdog_expired);
    pop         = in_run & ~stop_run & ~fifo_empty & (~m_valid_q | m_ready) &
                  (cont_q | (remaining_q != '0));
    last_pop    = pop & ~cont_q & (remaining_q == CW'(1));
    remaining_d = remaining_q;
    if (pop && !cont_q) begin
      remaining_d = remaining_q - CW'(1);
    end
  end

  // FLUSH pops unconditionally so stale words never reach the output register.
  assign fifo_rd   = (state_q == FLUSH) ? ~fifo_empty : pop;
  assign i2s_en    = in_run;
  assign busy      = (state_q != IDLE);
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign overrun   = overrun_q;
  assign remaining = remaining_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      overrun_q   <= 1'b0;
      cont_q      <= 1'b0;
      remaining_q <= '0;
`ifdef I2S_CAPTURE_CTRL_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (in_run && fifo_full) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= FLUSH;
            remaining_q <= sample_count;
            cont_q      <= (sample_count == '0);
            aborted_q   <= 1'b0;
`ifdef I2S_CAPTURE_CTRL_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
          end
        end
        FLUSH: begin
          if (stop) begin
            state_q   <= IDLE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (fifo_empty) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (pop) begin
            m_data_q    <= fifo_rdata;
            m_valid_q   <= 1'b1;
            m_last_q    <= last_pop;
            remaining_q <= remaining_d;
            if (last_pop) begin
              state_q <= DRAIN;
            end
          end else if (take) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
          end
          // An aborted session still hands over its pending word, marked as last.
          if (stop_run) begin
            state_q   <= DRAIN;
            aborted_q <= 1'b1;
            if (m_valid_q && !m_ready) begin
              m_last_q <= 1'b1;
            end
`ifdef I2S_CAPTURE_CTRL_TIMEOUT_EN
            if (wdog_expired) begin
              timeout_q <= 1'b1;
            end
`endif
          end
        end
        DRAIN: begin
          if (!m_valid_q || m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            state_q   <= IDLE;
            done_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed bench for i2s_capture_ctrl with a behavioural FWFT FIFO and an output monitor.
module tb_i2s_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear_overrun, fifo_full, m_ready;
  logic [15:0] sample_count;
  logic        i2s_en, fifo_rd, m_valid, m_last, busy, done, aborted, overrun;
  logic [31:0] m_data;
  logic [15:0] remaining;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rdata = '0;
`ifdef I2S_CAPTURE_CTRL_TIMEOUT_EN
  logic        timeout;
`endif

  logic        push_vld = 1'b0;
  logic [31:0] push_dat = '0;

  logic [31:0] fq[$];
  logic [31:0] got_dat[$];
  logic        got_last[$];
  int          pop_cnt = 0, done_cnt = 0, cyc = 0, last_pop_cyc = -1, en_fall_cyc = -2;
  logic        done_abort = 1'b0, en_prev = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_capture_ctrl #(.DW(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_count(sample_count),
    .clear_overrun(clear_overrun), .i2s_en(i2s_en), .fifo_rd(fifo_rd),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_rdata(fifo_rdata),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .aborted(aborted), .overrun(overrun),
`ifdef I2S_CAPTURE_CTRL_TIMEOUT_EN
    .timeout(timeout),
`endif
    .remaining(remaining)
  );

  // FWFT FIFO model and output-stream monitor; status updates land after the edge.
  always @(posedge clk) begin
    if (fifo_rd && fq.size() != 0) begin
      void'(fq.pop_front());
      pop_cnt++;
      if (i2s_en) last_pop_cyc = cyc;
    end
    if (push_vld) fq.push_back(push_dat);
    fifo_empty <= (fq.size() == 0);
    fifo_rdata <= (fq.size() != 0) ? fq[0] : 32'h0;
    if (m_valid && m_ready) begin
      got_dat.push_back(m_data);
      got_last.push_back(m_last);
    end
    if (done) begin
      done_cnt++;
      done_abort = aborted;
    end
    if (en_prev && !i2s_en) en_fall_cyc = cyc;
    en_prev = i2s_en;
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the word enters the FIFO on the following posedge.
  task automatic push(input logic [31:0] w);
    push_vld = 1'b1;
    push_dat = w;
    @(negedge clk);
    push_vld = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    sample_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int i;
    for (i = 0; i < 50 && !i2s_en; i++) @(negedge clk);
    chk(tag, i2s_en, 1);
  endtask

  task automatic wait_vld(input string tag);
    int i;
    for (i = 0; i < 50 && !m_valid; i++) @(negedge clk);
    chk(tag, m_valid, 1);
  endtask

  task automatic wait_done(input string tag, input int prev, input int max);
    int i;
    for (i = 0; i < max && done_cnt == prev; i++) @(negedge clk);
    chk(tag, done_cnt != prev, 1);
  endtask

  initial begin
    int p0, n0, d0;
    logic [31:0] exp_w;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear_overrun = 1'b0;
    fifo_full = 1'b0; m_ready = 1'b0; sample_count = '0;
    repeat (2) @(negedge clk);
    chk("reset_flags", {i2s_en, fifo_rd, m_valid, m_last, busy, done, aborted, overrun}, 8'h00);
    chk("reset_remaining", remaining, 0);
    chk("reset_m_data", m_data, 0);
`ifdef I2S_CAPTURE_CTRL_TIMEOUT_EN
    chk("reset_timeout", timeout, 0);
`endif
    rst = 1'b0;

    // Counted session with two stale words ahead of the real data.
    push(32'h5A5A_0001);
    push(32'h5A5A_0002);
    chk("idle_no_pop", pop_cnt, 0);
    d0 = done_cnt;
    do_start(16'd4);
    chk("flush_state", {busy, i2s_en, fifo_rd}, 3'b101);
    chk("flush_remaining", remaining, 4);
    wait_en("t1_enter_run");
    chk("flush_discards", pop_cnt, 2);
    m_ready = 1'b1;
    n0 = got_dat.size();
    for (int i = 0; i < 4; i++) push(32'h0000_00A1 + i);
    wait_done("t1_done", d0, 50);
    chk("t1_count", got_dat.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      exp_w = 32'h0000_00A1 + i;
      chk($sformatf("t1_word%0d", i), got_dat[n0+i], exp_w);
      chk($sformatf("t1_last%0d", i), got_last[n0+i], (i == 3));
    end
    chk("t1_aborted", done_abort, 0);
    chk("t1_en_fall", en_fall_cyc, last_pop_cyc + 1);
    chk("t1_remaining", remaining, 0);

    // Output stall: data must hold and no pops while m_ready is low.
    m_ready = 1'b0;
    d0 = done_cnt;
    n0 = got_dat.size();
    do_start(16'd3);
    wait_en("t2_enter_run");
    p0 = pop_cnt;
    push(32'hB000_0000);
    push(32'hB000_0001);
    push(32'hB000_0002);
    do_start(16'd9);
    chk("t2_start_ignored", remaining, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t2_stall%0d", i), {m_valid, fifo_rd, m_data}, {2'b10, 32'hB000_0000});
    end
    chk("t2_stall_pops", pop_cnt - p0, 1);
    m_ready = 1'b1;
    wait_done("t2_done", d0, 50);
    chk("t2_count", got_dat.size() - n0, 3);
    chk("t2_word2", got_dat[n0+2], 32'hB000_0002);
    chk("t2_last", {got_last[n0], got_last[n0+1], got_last[n0+2]}, 3'b001);
    chk("t2_aborted", done_abort, 0);

    // Continuous session aborted by stop with one word pending.
    d0 = done_cnt;
    n0 = got_dat.size();
    do_start(16'd0);
    wait_en("t3_enter_run");
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) push(32'hC000_0000 + i);
    repeat (3) @(negedge clk);
    chk("t3_cont_remaining", remaining, 0);
    m_ready = 1'b0;
    push(32'hC000_000A);
    wait_vld("t3_pending");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t3_drain", {m_valid, m_last, i2s_en, busy, m_data}, {4'b1101, 32'hC000_000A});
    m_ready = 1'b1;
    wait_done("t3_done", d0, 50);
    chk("t3_aborted", done_abort, 1);
    chk("t3_count", got_dat.size() - n0, 11);
    for (int i = 0; i < 11; i++) begin
      exp_w = 32'hC000_0000 + i;
      chk($sformatf("t3_word%0d", i), got_dat[n0+i], exp_w);
      chk($sformatf("t3_last%0d", i), got_last[n0+i], (i == 10));
    end
    push(32'hC000_000B);
    repeat (3) @(negedge clk);
    chk("t3_no_more_pops", pop_cnt - p0, 11);

    // Sticky overrun; set beats clear in the same cycle.
    d0 = done_cnt;
    do_start(16'd2);
    wait_en("t4_enter_run");
    chk("t4_overrun_pre", overrun, 0);
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    chk("t4_overrun_set", overrun, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("t4_done", d0, 50);
    @(negedge clk);
    chk("t4_overrun_idle", {busy, overrun}, 2'b01);
    d0 = done_cnt;
    do_start(16'd2);
    wait_en("t4_enter_run2");
    fifo_full = 1'b1;
    clear_overrun = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    chk("t4_set_wins", overrun, 1);
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("t4_cleared", overrun, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("t4_done2", d0, 50);

    // Reset mid-RUN with a pending word, then stop during FLUSH.
    m_ready = 1'b0;
    do_start(16'd5);
    wait_en("t5_enter_run");
    push(32'hD000_0000);
    wait_vld("t5_pending");
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_flags", {i2s_en, fifo_rd, m_valid, m_last, busy, done, aborted, overrun}, 8'h00);
    chk("t5_rst_data", {m_data, remaining}, 48'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_done", done_cnt, d0);
    m_ready = 1'b1;
    do_start(16'd1);
    chk("t5_flush", {busy, i2s_en, remaining}, {2'b10, 16'd1});
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t5_flush_stop", {done, aborted, busy}, 3'b110);

`ifdef I2S_CAPTURE_CTRL_TIMEOUT_EN
    // Watchdog: RUN with no data eventually aborts the session.
    d0 = done_cnt;
    do_start(16'd1);
    wait_en("t6_enter_run");
    wait_done("t6_done", d0, 70000);
    chk("t6_timeout", timeout, 1);
    chk("t6_aborted", done_abort, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
